// File: rtl/meteor_pkg.sv
// Shared playfield constants, FSM state encoding and column-source constants for the meteor engine.
package meteor_pkg;

    localparam int PF_W     = 160;
    localparam int PF_H     = 120;
    localparam int PF_MET_W = 8;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] COL_STEP  = 8'd37;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        FALL  = 2'd2,
        GONE  = 2'd3
    } state_t;

endpackage

// File: rtl/meteor_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) with synchronous reload and step enable.
// Seeded non-zero, so the sequence never reaches the all-zero lock-up state.
module meteor_lfsr8
    import meteor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (clr) begin
            lfsr_d = LFSR_SEED;
        end else if (en) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/meteor_fall.sv
// Falling-meteor engine: advances one meteor per frame, pulses a score on exit, respawns after a delay.
// Define METEOR_RANDOM_X_EN to take spawn columns from an LFSR instead of a stride-37 counter.
module meteor_fall
    import meteor_pkg::*;
#(
    parameter int SCREEN_W       = PF_W,
    parameter int SCREEN_H       = PF_H,
    parameter int MET_W          = PF_MET_W,
    parameter int MAX_STEP       = 31,
    parameter int RESPAWN_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       run,
    input  logic       frame,
    input  logic [7:0] speed,
    output logic [7:0] o_x,
    output logic [6:0] o_y,
    output logic       o_active,
    output logic       o_moved,
    output logic       o_passed
);

    localparam logic [7:0] X_MAX    = 8'(SCREEN_W - MET_W);
    localparam logic [7:0] Y_LIM    = 8'(SCREEN_H);
    localparam logic [7:0] STEP_MAX = 8'(MAX_STEP);
    localparam logic [3:0] RESP_CNT = 4'(RESPAWN_FRAMES);

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic       active_q, active_d;
    logic       moved_q, moved_d;
    logic       passed_q, passed_d;
    logic [3:0] cnt_q, cnt_d;

    logic [7:0] step;
    logic [7:0] sum;
    logic [7:0] spawn_x;
    logic       spawn_now;

    assign spawn_now = run && !restart && (state_q == SPAWN);

`ifdef METEOR_RANDOM_X_EN
    logic [7:0] lfsr_val;

    meteor_lfsr8 u_lfsr (
        .clk (i_clk),
        .rst (reset),
        .clr (restart),
        .en  (1'b1),
        .q   (lfsr_val)
    );

    // Fold the out-of-range tail back into the legal column span.
    assign spawn_x = (lfsr_val > X_MAX) ? (lfsr_val - X_MAX) : lfsr_val;
`else
    logic [7:0] col_q, col_d;
    logic [7:0] col_sum;

    always_comb begin
        col_sum = col_q + COL_STEP;
        col_d   = col_q;
        if (restart) begin
            col_d = '0;
        end else if (spawn_now) begin
            col_d = (col_sum > X_MAX) ? (col_sum - (X_MAX + 8'd1)) : col_sum;
        end
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    assign spawn_x = col_q;
`endif

    always_comb begin
        step     = (speed > STEP_MAX) ? STEP_MAX : speed;
        sum      = {1'b0, y_q} + step;
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        moved_d  = 1'b0;
        passed_d = 1'b0;

        if (restart) begin
            state_d  = IDLE;
            x_d      = '0;
            y_d      = '0;
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (run) begin
            case (state_q)
                IDLE: state_d = SPAWN;
                SPAWN: begin
                    x_d      = spawn_x;
                    y_d      = '0;
                    active_d = 1'b1;
                    state_d  = FALL;
                end
                FALL: begin
                    if (frame) begin
                        if (sum < Y_LIM) begin
                            y_d     = sum[6:0];
                            moved_d = 1'b1;
                        end else begin
                            active_d = 1'b0;
                            passed_d = 1'b1;
                            cnt_d    = RESP_CNT;
                            state_d  = GONE;
                        end
                    end
                end
                GONE: begin
                    if (frame) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_d = SPAWN;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            active_q <= 1'b0;
            moved_q  <= 1'b0;
            passed_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            active_q <= active_d;
            moved_q  <= moved_d;
            passed_q <= passed_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_x      = x_q;
    assign o_y      = y_q;
    assign o_active = active_q;
    assign o_moved  = moved_q;
    assign o_passed = passed_q;

endmodule

// File: doc/meteor_fall.md
# meteor_fall

Falling-meteor motion engine for the dodger playfield. It consumes the per-frame speed value from the speed stage and the frame tick, and advances one meteor down the screen by that many pixels per frame. When the meteor leaves the bottom edge it emits a score pulse, waits a fixed number of frames, then respawns at the top at a new column. It sits between the speed stage and the renderer/collision logic, and drives the meteor's x/y position.

## Interface
Parameters:
- SCREEN_W, 160, playfield width in pixels
- SCREEN_H, 120, playfield height in pixels
- MET_W, 8, meteor sprite width; x is kept in 0..SCREEN_W-MET_W
- MAX_STEP, 31, per-frame step saturation limit
- RESPAWN_FRAMES, 2, frames spent off-screen before respawn (1..15)

Ports:
- i_clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- restart  input  1  synchronous game restart; same effect as reset
- run  input  1  game running; 0 freezes motion
- frame  input  1  one-cycle frame tick
- speed  input  8  pixels per frame from the speed stage
- o_x  output  8  meteor column (left edge)
- o_y  output  7  meteor row (top edge)
- o_active  output  1  meteor on screen (draw/collide enable)
- o_moved  output  1  one-cycle pulse: position updated this frame
- o_passed  output  1  one-cycle pulse: meteor exited bottom (score)

## Operation
- States: IDLE, SPAWN, FALL, GONE.
- IDLE: entered on reset/restart; o_active=0. Moves to SPAWN when run=1.
- SPAWN: one clock. Loads o_x from the column source, sets o_y=0 and o_active=1, then moves to FALL.
- FALL, on frame with run=1:
  - step = min(speed, MAX_STEP).
  - sum = o_y + step, computed 8 bits wide, no wrap.
  - sum < SCREEN_H: o_y <= sum, pulse o_moved.
  - sum >= SCREEN_H: o_active <= 0, o_y holds its last value, pulse o_passed, load the frame counter with RESPAWN_FRAMES, go to GONE.
- GONE: decrement the counter on each frame with run=1. The decrement that reaches 0 moves to SPAWN.
- speed=0: o_y unchanged, but o_moved still pulses.
- run=0: all state frozen, frame ignored, no pulses. Motion resumes on the next frame after run returns to 1.
- restart with frame in the same cycle: restart wins; result is IDLE with no pulses.
- Reset or restart mid-fall: the meteor is discarded and a new spawn follows.

## Timing
- Reset values: o_x=0, o_y=0, o_active=0, o_moved=0, o_passed=0, state IDLE, column source seeded to 8'hA5.
- Frame at cycle t in FALL: o_y, o_moved and o_passed are valid at t+1.
- o_moved and o_passed are never asserted in the same cycle.
- GONE to visible: SPAWN occurs one clock after the last counted frame; o_active rises the clock after that.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- METEOR_RANDOM_X_EN defined:
  - Column source is an 8-bit Fibonacci LFSR (taps 8,6,5,4), advanced every clock, never 0.
  - SPAWN takes v=lfsr. If v > SCREEN_W-MET_W, then v <= v-(SCREEN_W-MET_W).
  - With the defaults this gives x in 0..152.
- Undefined:
  - Column source is a counter that steps by 37 on each SPAWN, wrapping modulo SCREEN_W-MET_W+1.
  - The first spawn after reset is at x=0.

## Structure
- Shared package meteor_pkg: playfield constants (SCREEN_W, SCREEN_H, MET_W), state enum {IDLE,SPAWN,FALL,GONE}, LFSR seed constant.
- Sub-module meteor_lfsr8: 8-bit LFSR with enable, used only when METEOR_RANDOM_X_EN is defined.

## Test plan
- Reset, run=1, speed=3, then 5 frames → o_active=1 from the second clock; o_y sequence 3,6,9,12,15, one o_moved per frame.
- speed=20 starting from o_y=100 → next frame gives sum 120 ≥ 120: o_passed pulse, o_active=0, o_y stays 100. Two further frames → SPAWN, o_y=0, o_active=1.
- speed=200 → step saturates to 31: o_y goes 0→31→62→93, then the next frame produces o_passed.
- run=0 held across 3 frames at o_y=40 → o_y stays 40, no pulses. run=1 plus one frame at speed 7 → o_y=47.
- restart asserted in the same cycle as frame at o_y=60 → IDLE, o_y=0, no o_moved. Respawn follows at the next valid spawn column.
- Macro on: 50 respawns, every o_x ≤ 152 and not all equal. Macro off: spawn columns 0,37,74,111,148,32.
